// File: rtl/accel_pkg.sv
// Shared constants and helpers for the accelerator datapath blocks.
//   ACC_W / Q_W / MULT_W / SHIFT_W : accumulator, quantized output,
//                                    scale multiplier and shift widths
//   PROD_W                         : full-precision scaled product width
//   Q_MIN / Q_MAX                  : signed 8-bit output range
//   beat_cfg_t                     : per-beat scale config carried with a beat
//   sat_add()                      : signed add clamped to the ACC_W range
package accel_pkg;

    localparam int ACC_W   = 32;
    localparam int Q_W     = 8;
    localparam int MULT_W  = 16;
    localparam int SHIFT_W = 5;
    localparam int PROD_W  = ACC_W + MULT_W;
    localparam int Q_MIN   = -128;
    localparam int Q_MAX   = 127;

    typedef struct packed {
        logic [MULT_W-1:0]  mult;
        logic [SHIFT_W-1:0] shift;
        logic               relu_en;
    } beat_cfg_t;

    // One guard bit detects overflow; the result pins to the nearest rail.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/requant_round_clamp.sv
// Combinational requantizer: optional round-half-up, arithmetic right shift,
// then clamp to the signed 8-bit range (or [0,127] with ReLU).
//   prod    : full-precision scaled product
//   shift   : right shift amount, 0..31
//   relu_en : clamp negatives to zero
//   q       : requantized value
//   sat     : value was clamped at a rail (ReLU zeroing excluded)
module requant_round_clamp
    import accel_pkg::*;
#(
    parameter int unsigned ROUND_EN = 1
) (
    input  logic signed [PROD_W-1:0]  prod,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      relu_en,
    output logic signed [Q_W-1:0]     q,
    output logic                      sat
);

    localparam logic signed [PROD_W:0] HI = (PROD_W+1)'(Q_MAX);
    localparam logic signed [PROD_W:0] LO = (PROD_W+1)'(Q_MIN);

    // One extra bit so the rounding increment can never wrap the product.
    logic signed [PROD_W:0] ext;
    logic signed [PROD_W:0] rnd_inc;
    logic signed [PROD_W:0] shifted;

    always_comb begin
        ext     = {prod[PROD_W-1], prod};
        rnd_inc = '0;
        if (ROUND_EN != 0 && shift != '0) begin
            rnd_inc = (PROD_W+1)'(1) << (shift - SHIFT_W'(1));
        end
        shifted = (ext + rnd_inc) >>> shift;

        q   = shifted[Q_W-1:0];
        sat = 1'b0;
        if (shifted > HI) begin
            q   = Q_W'(Q_MAX);
            sat = 1'b1;
        end else if (relu_en && shifted < 0) begin
            q   = '0;
        end else if (!relu_en && shifted < LO) begin
            q   = Q_W'(Q_MIN);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/acc_requant.sv
// Three-stage requantization pipeline for mac8 accumulator drains:
// S1 saturating bias add, S2 scale multiply, S3 round/shift/clamp.
// A single global advance stalls every stage together when the output
// is held, so bubbles stay in place and per-beat config rides with its beat.
//   clk, rst            : clock, synchronous active-high reset
//   acc_in/acc_valid    : accumulator beat in; acc_ready = accepting
//   bias/mult/shift/relu_en : per-beat config sampled with the beat
//   q_out/q_valid/q_sat : requantized result out; q_ready = downstream taking it
//   sat_cnt/cnt_clr     : saturating count of clamped beats delivered, clear
module acc_requant
    import accel_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned ROUND_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [ACC_W-1:0]   acc_in,
    input  logic                      acc_valid,
    output logic                      acc_ready,
    input  logic signed [ACC_W-1:0]   bias,
    input  logic        [MULT_W-1:0]  mult,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      relu_en,
    output logic signed [Q_W-1:0]     q_out,
    output logic                      q_valid,
    input  logic                      q_ready,
    output logic                      q_sat,
    output logic        [CNT_W-1:0]   sat_cnt,
    input  logic                      cnt_clr
);

    logic advance;

    logic                      s1_v_q, s1_v_d;
    logic signed [ACC_W-1:0]   s1_sum_q, s1_sum_d;
    beat_cfg_t                 s1_cfg_q, s1_cfg_d;

    logic                      s2_v_q, s2_v_d;
    logic signed [PROD_W-1:0]  s2_prod_q, s2_prod_d;
    logic        [SHIFT_W-1:0] s2_shift_q, s2_shift_d;
    logic                      s2_relu_q, s2_relu_d;

    logic                      q_valid_q, q_valid_d;
    logic signed [Q_W-1:0]     q_out_q, q_out_d;
    logic                      q_sat_q, q_sat_d;
    logic        [CNT_W-1:0]   sat_cnt_q, sat_cnt_d;

    logic signed [Q_W-1:0]     rc_q;
    logic                      rc_sat;

    requant_round_clamp #(
        .ROUND_EN (ROUND_EN)
    ) u_round_clamp (
        .prod    (s2_prod_q),
        .shift   (s2_shift_q),
        .relu_en (s2_relu_q),
        .q       (rc_q),
        .sat     (rc_sat)
    );

    always_comb begin
        advance   = !q_valid_q || q_ready;
        acc_ready = advance && !rst;

        s1_v_d     = s1_v_q;
        s1_sum_d   = s1_sum_q;
        s1_cfg_d   = s1_cfg_q;
        s2_v_d     = s2_v_q;
        s2_prod_d  = s2_prod_q;
        s2_shift_d = s2_shift_q;
        s2_relu_d  = s2_relu_q;
        q_valid_d  = q_valid_q;
        q_out_d    = q_out_q;
        q_sat_d    = q_sat_q;

        if (advance) begin
            s1_v_d   = acc_valid;
            s1_sum_d = sat_add(acc_in, bias);
            s1_cfg_d = '{mult: mult, shift: shift, relu_en: relu_en};

            // One signed 32x17 multiply (mult zero-extended) feeding a register.
            s2_v_d     = s1_v_q;
            s2_prod_d  = PROD_W'(s1_sum_q) * $signed(PROD_W'({1'b0, s1_cfg_q.mult}));
            s2_shift_d = s1_cfg_q.shift;
            s2_relu_d  = s1_cfg_q.relu_en;

            q_valid_d = s2_v_q;
            q_out_d   = rc_q;
            q_sat_d   = rc_sat;
        end

        sat_cnt_d = sat_cnt_q;
        if (cnt_clr) begin
            sat_cnt_d = '0;
        end else if (q_valid_q && q_ready && q_sat_q && sat_cnt_q != '1) begin
            sat_cnt_d = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_sum_q   <= '0;
            s1_cfg_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_prod_q  <= '0;
            s2_shift_q <= '0;
            s2_relu_q  <= 1'b0;
            q_valid_q  <= 1'b0;
            q_out_q    <= '0;
            q_sat_q    <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_sum_q   <= s1_sum_d;
            s1_cfg_q   <= s1_cfg_d;
            s2_v_q     <= s2_v_d;
            s2_prod_q  <= s2_prod_d;
            s2_shift_q <= s2_shift_d;
            s2_relu_q  <= s2_relu_d;
            q_valid_q  <= q_valid_d;
            q_out_q    <= q_out_d;
            q_sat_q    <= q_sat_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign q_out   = q_out_q;
    assign q_valid = q_valid_q;
    assign q_sat   = q_sat_q;
    assign sat_cnt = sat_cnt_q;

endmodule
